cordic_quadrant_prep: RTL

Upstream pre-stage for the `CORDIC` rotation core. It accepts a binary-angle rotation request `(angle, Xin, Yin)` through a valid/ready handshake. Angles in quadrants II and III are folded into [-90°, +90°) by pre-rotating the input vector ±90°. The result is presented to the CORDIC inputs through a 2-stage elastic pipeline with backpressure. Without this stage the core's ±99.7° convergence range cannot cover the full circle.

---
 rtl/cordic_quadrant_prep.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cordic_quadrant_prep.sv
// Folds quadrant II/III rotation requests into [-90,+90) by a +/-90 degree pre-rotation for the CORDIC core.
// Two-stage elastic pipeline; ready ripples back combinationally from out_ready.
module cordic_quadrant_prep #(
  parameter int ANGLE_W = 32,
  parameter int DATA_W  = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ANGLE_W-1:0] in_angle,
  input  logic [DATA_W-1:0]  in_x,
  input  logic [DATA_W-1:0]  in_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ANGLE_W-1:0] angle,
  output logic [DATA_W-1:0]  Xin,
  output logic [DATA_W-1:0]  Yin,
  output logic [1:0]         quad,
  output logic               sat,
  output logic [CNT_W-1:0]   sample_count
);

  localparam logic [ANGLE_W-1:0] QUARTER = {2'b01, {(ANGLE_W-2){1'b0}}};
  localparam logic [DATA_W-1:0]  DMIN    = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0]  DMAX    = ~DMIN;

  logic               s1_valid_q, s1_valid_d;
  logic [ANGLE_W-1:0] s1_angle_q, s1_angle_d;
  logic [DATA_W-1:0]  s1_x_q, s1_x_d;
  logic [DATA_W-1:0]  s1_y_q, s1_y_d;

  logic               s2_valid_q, s2_valid_d;
  logic [ANGLE_W-1:0] s2_angle_q, s2_angle_d;
  logic [DATA_W-1:0]  s2_x_q, s2_x_d;
  logic [DATA_W-1:0]  s2_y_q, s2_y_d;
  logic [1:0]         s2_quad_q, s2_quad_d;
  logic               s2_sat_q, s2_sat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               adv1, adv2;
  logic [1:0]         s1_quad;
  logic [DATA_W-1:0]  neg_x, neg_y;
  logic               neg_x_sat, neg_y_sat;
  logic [ANGLE_W-1:0] fold_angle;
  logic [DATA_W-1:0]  fold_x, fold_y;
  logic               fold_sat;

  always_comb begin
    adv2     = !s2_valid_q || out_ready;
    adv1     = !s1_valid_q || adv2;
    in_ready = adv1 && !reset;
  end

  // Stage 1: capture the request.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_angle_d = s1_angle_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    if (adv1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_angle_d = in_angle;
        s1_x_d     = in_x;
        s1_y_d     = in_y;
      end
    end
  end

  // Negating the most negative value has no representation; clamp it to the positive limit.
  always_comb begin
    s1_quad   = s1_angle_q[ANGLE_W-1:ANGLE_W-2];
    neg_x_sat = (s1_x_q == DMIN);
    neg_y_sat = (s1_y_q == DMIN);
    neg_x     = neg_x_sat ? DMAX : (DATA_W'(0) - s1_x_q);
    neg_y     = neg_y_sat ? DMAX : (DATA_W'(0) - s1_y_q);
  end

  always_comb begin
    fold_angle = s1_angle_q;
    fold_x     = s1_x_q;
    fold_y     = s1_y_q;
    fold_sat   = 1'b0;
    case (s1_quad)
      2'b01: begin
        fold_angle = s1_angle_q - QUARTER;
        fold_x     = neg_y;
        fold_y     = s1_x_q;
        fold_sat   = neg_y_sat;
      end
      2'b10: begin
        fold_angle = s1_angle_q + QUARTER;
        fold_x     = s1_y_q;
        fold_y     = neg_x;
        fold_sat   = neg_x_sat;
      end
      default: ;
    endcase
  end

  // Stage 2: registered outputs, held while stalled.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_angle_d = s2_angle_q;
    s2_x_d     = s2_x_q;
    s2_y_d     = s2_y_q;
    s2_quad_d  = s2_quad_q;
    s2_sat_d   = s2_sat_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_angle_d = fold_angle;
        s2_x_d     = fold_x;
        s2_y_d     = fold_y;
        s2_quad_d  = s1_quad;
        s2_sat_d   = fold_sat;
      end
    end
    cnt_d = cnt_q;
    if (s2_valid_q && out_ready) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_angle_q <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_angle_q <= '0;
      s2_x_q     <= '0;
      s2_y_q     <= '0;
      s2_quad_q  <= '0;
      s2_sat_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_angle_q <= s1_angle_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s2_valid_q <= s2_valid_d;
      s2_angle_q <= s2_angle_d;
      s2_x_q     <= s2_x_d;
      s2_y_q     <= s2_y_d;
      s2_quad_q  <= s2_quad_d;
      s2_sat_q   <= s2_sat_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign angle        = s2_angle_q;
  assign Xin          = s2_x_q;
  assign Yin          = s2_y_q;
  assign quad         = s2_quad_q;
  assign sat          = s2_sat_q;
  assign sample_count = cnt_q;

endmodule
